serial_deserializer: RTL

- Serial-to-parallel stage that consumes the single-bit stream produced by the d_ff flop chain.
- Assembles WIDTH-bit frames delimited by a start-of-frame strobe.
- Presents each frame on a valid/ready parallel output held in a one-entry buffer.
- Flags overrun (output busy) and framing errors (premature start of frame).

---
 rtl/deser_pkg.sv | 16 +
 rtl/serial_deserializer_if.sv | 25 ++
 rtl/deser_out_buf.sv | 62 ++++++
 rtl/serial_deserializer.sv | 105 ++++++++++
 4 files changed

// File: rtl/deser_pkg.sv
// Shared types and sizing helpers for the serial deserializer.
package deser_pkg;

  localparam int MAX_WIDTH = 32;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } deser_state_e;

  // Bit counter must hold values 0..WIDTH-1 with headroom for WIDTH itself.
  function automatic int cnt_width(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/serial_deserializer_if.sv
// Serial input and parallel valid/ready output bundle of the deserializer.
interface serial_deserializer_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
);
  logic             serial_in;
  logic             serial_valid;
  logic             sof;
  logic [WIDTH-1:0] par_data;
  logic             par_valid;
  logic             par_ready;
  logic             overrun;
  logic             frame_err;
  logic [CNT_W-1:0] overrun_cnt;

  modport master (
    output serial_in, serial_valid, sof, par_ready,
    input  par_data, par_valid, overrun, frame_err, overrun_cnt
  );

  modport slave (
    input  serial_in, serial_valid, sof, par_ready,
    output par_data, par_valid, overrun, frame_err, overrun_cnt
  );
endinterface

// File: rtl/deser_out_buf.sv
// One-entry valid/ready holding register; drops frames that arrive while full.
module deser_out_buf #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             frame_done_i,
  input  logic [WIDTH-1:0] frame_data_i,
  input  logic             par_ready_i,
  output logic [WIDTH-1:0] par_data_o,
  output logic             par_valid_o,
  output logic             overrun_o,
  output logic [CNT_W-1:0] overrun_cnt_o
);

  logic [WIDTH-1:0] data_q,  data_d;
  logic             valid_q, valid_d;
  logic             ovr_q,   ovr_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic             load, drop;

  // Load when empty or draining this cycle; otherwise a new frame is lost.
  always_comb begin
    load    = frame_done_i & (~valid_q | par_ready_i);
    drop    = frame_done_i & valid_q & ~par_ready_i;
    data_d  = data_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    ovr_d   = drop;
    if (load) begin
      data_d  = frame_data_i;
      valid_d = 1'b1;
    end else if (valid_q & par_ready_i) begin
      valid_d = 1'b0;
    end
    if (drop && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Output register bank with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign par_data_o    = data_q;
  assign par_valid_o   = valid_q;
  assign overrun_o     = ovr_q;
  assign overrun_cnt_o = cnt_q;

endmodule

// File: rtl/serial_deserializer.sv
// Serial-to-parallel framer: sof-delimited WIDTH-bit frames into a one-entry buffer.
module serial_deserializer
  import deser_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1,
  parameter int CNT_W     = 8
) (
  input logic            clk,
  input logic            rst,
  serial_deserializer_if.slave bus
);

  localparam int CW = cnt_width(WIDTH);

  deser_state_e     state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] shreg_q;
  logic             frame_err_q;

  logic [WIDTH-1:0] start_val;
  logic [WIDTH-1:0] shift_val;
  logic             frame_done;

  // First-bit seed and shifted value for the configured bit order; a frame
  // completes combinationally so the buffer loads on the sampling edge.
  always_comb begin
    start_val = '0;
    shift_val = '0;
    if (MSB_FIRST != 0) begin
      start_val = {{(WIDTH-1){1'b0}}, bus.serial_in};
      shift_val = {shreg_q[WIDTH-2:0], bus.serial_in};
    end else begin
      start_val = {bus.serial_in, {(WIDTH-1){1'b0}}};
      shift_val = {bus.serial_in, shreg_q[WIDTH-1:1]};
    end
    frame_done = bus.serial_valid & ~bus.sof & (state_q == SHIFT) &
                 (cnt_q == CW'(WIDTH-1));
  end

  // Frame assembly FSM; sof mid-frame restarts on the current bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      shreg_q     <= '0;
      frame_err_q <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;
      if (bus.serial_valid) begin
        case (state_q)
          IDLE: begin
            if (bus.sof) begin
              shreg_q <= start_val;
              cnt_q   <= CW'(1);
              state_q <= SHIFT;
            end
          end
          SHIFT: begin
            if (bus.sof) begin
              frame_err_q <= 1'b1;
              shreg_q     <= start_val;
              cnt_q       <= CW'(1);
            end else if (frame_done) begin
              shreg_q <= shift_val;
              cnt_q   <= '0;
              state_q <= IDLE;
            end else begin
              shreg_q <= shift_val;
              cnt_q   <= cnt_q + 1'b1;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  logic [WIDTH-1:0] par_data_w;
  logic             par_valid_w;
  logic             overrun_w;
  logic [CNT_W-1:0] overrun_cnt_w;

  deser_out_buf #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_out_buf (
    .clk           (clk),
    .rst           (rst),
    .frame_done_i  (frame_done),
    .frame_data_i  (shift_val),
    .par_ready_i   (bus.par_ready),
    .par_data_o    (par_data_w),
    .par_valid_o   (par_valid_w),
    .overrun_o     (overrun_w),
    .overrun_cnt_o (overrun_cnt_w)
  );

  assign bus.par_data    = par_data_w;
  assign bus.par_valid   = par_valid_w;
  assign bus.overrun     = overrun_w;
  assign bus.frame_err   = frame_err_q;
  assign bus.overrun_cnt = overrun_cnt_w;

endmodule
